// File: rtl/spi_rx_pkg.sv
// Shared types and sizing helpers for the read-only SPI frame master.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_rx_state_t;

  localparam int FRAME_BITS = 32;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  // Counter holds (N-1) for the largest wait N, so clog2(N) bits suffice.
  function automatic int cnt_bits(input int clk_div, input int cs_setup, input int cs_hold);
    int m;
    m = clk_div;
    if (cs_setup > m) m = cs_setup;
    if (cs_hold > m)  m = cs_hold;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_bits(4, 2, 2);

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_rx_master.sv
// Read-only SPI master: on request, clocks one 32-bit MSB-first frame in from
// a thermocouple converter and presents it with a one-cycle done pulse.
module spi_rx_master
  import spi_rx_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_ena,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  spi_not_busy,
  output logic [FRAME_BITS-1:0] spi_rx_data,
  output logic                  rx_done
);

  localparam int                CTR_W      = cnt_bits(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam logic [CTR_W-1:0]  HALF_LOAD  = CTR_W'(CLK_DIV - 1);
  localparam logic [CTR_W-1:0]  SETUP_LOAD = CTR_W'(CS_SETUP - 1);
  localparam logic [CTR_W-1:0]  HOLD_LOAD  = CTR_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(FRAME_BITS - 1);

  spi_rx_state_t         state_q, state_d;
  logic [CTR_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  idle_q, idle_d;
  logic                  miso_s;

  sync2 u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d_i (miso),
    .q_o (miso_s)
  );

  // NOTE: every register here is a plain flop (no RAM), so all of them take the
  // async reset; that is what makes a mid-frame reset drop cs_n/sclk at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (spi_ena) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end

      SETUP: begin
        sclk_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = HALF_LOAD;
          bit_d   = LAST_BIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = HALF_LOAD;
        end else begin
          // Last cycle of the high phase: sample, then fall or finish.
          shift_d = {shift_q[FRAME_BITS-2:0], miso_s};
          sclk_d  = 1'b0;
          if (bit_q == '0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
            data_d  = shift_d;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q - 1'b1;
            cnt_d = HALF_LOAD;
          end
        end
      end

      HOLD: begin
        sclk_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // Pin-level outputs are registered from the next state.
  assign cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
  assign idle_d = (state_d == IDLE);

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign spi_not_busy = idle_q;
  assign spi_rx_data  = data_q;
  assign rx_done      = done_q;

endmodule
